// File: rtl/fp_pkg.sv
// Shared definitions for the packed single-precision datapath: field widths,
// FSM states and the unpacked operand representation.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 28;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam int               BIAS    = 127;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    OP,
    NORM,
    DONE
  } state_e;

  // mant layout: [27] carry, [26] hidden, [25:3] frac, [2] G, [1] R, [0] S
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } operand_t;

  // exp == 0 collapses to zero, so denormals never reach the datapath.
  function automatic operand_t unpack_op(input logic [31:0] word);
    operand_t op;
    op.sign = word[31];
    op.exp  = word[30:23];
    op.mant = (word[30:23] == '0) ? '0 : {2'b01, word[22:0], 3'b000};
    return op;
  endfunction

  function automatic logic [MANT_W-1:0] shr_sticky(input logic [MANT_W-1:0] m);
    return {1'b0, m[MANT_W-1:2], m[1] | m[0]};
  endfunction

endpackage

// File: rtl/fp_unpack_swap.sv
// Magnitude compare and swap for the subtractor: X gets the larger operand,
// Y's mantissa and the alignment distance come out ready for the ALIGN loop.
module fp_unpack_swap
  import fp_pkg::*;
#(
  parameter int ALIGN_CAP = 26
) (
  input  operand_t          a_i,
  input  operand_t          b_i,
  output operand_t          x_o,
  output logic [MANT_W-1:0] y_mant_o,
  output logic [EXP_W-1:0]  diff_o,
  output logic              sub_o
);

  localparam logic [EXP_W-1:0] CAP = EXP_W'(ALIGN_CAP);

  logic              a_larger;
  logic [EXP_W-1:0]  small_exp;
  logic [EXP_W-1:0]  raw_diff;
  logic [MANT_W-1:0] small_mant;

  always_comb begin
    // Ties keep A as X; the mantissa carries the hidden bit, so this orders by {exp,frac}.
    a_larger   = {a_i.exp, a_i.mant} >= {b_i.exp, b_i.mant};
    x_o        = a_larger ? a_i : b_i;
    small_exp  = a_larger ? b_i.exp  : a_i.exp;
    small_mant = a_larger ? b_i.mant : a_i.mant;
    raw_diff   = x_o.exp - small_exp;
    sub_o      = a_i.sign ^ b_i.sign;

    // Far below X's guard bits Y only matters as "nonzero", so skip the shift loop.
    if (raw_diff >= CAP) begin
      y_mant_o = {{(MANT_W-1){1'b0}}, |small_mant};
      diff_o   = '0;
    end else begin
      y_mant_o = small_mant;
      diff_o   = raw_diff;
    end
  end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Iterative single-precision subtractor (Out = A - B, round toward zero):
// one alignment or normalisation shift per cycle behind valid/ready handshakes.
module fp_subtractor_seq
  import fp_pkg::*;
#(
  parameter int ALIGN_CAP = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Out,
  output logic        busy
);

  state_e            state_q, state_d;
  operand_t          a_q, a_d;
  operand_t          b_q, b_d;
  operand_t          x_q, x_d;
  logic [MANT_W-1:0] y_q, y_d;
  logic [EXP_W-1:0]  diff_q, diff_d;
  logic              sub_q, sub_d;
  logic [31:0]       out_q, out_d;
  logic              out_valid_q, out_valid_d;

  operand_t          us_x;
  logic [MANT_W-1:0] us_y;
  logic [EXP_W-1:0]  us_diff;
  logic              us_sub;

  fp_unpack_swap #(
    .ALIGN_CAP (ALIGN_CAP)
  ) u_unpack_swap (
    .a_i      (a_q),
    .b_i      (b_q),
    .x_o      (us_x),
    .y_mant_o (us_y),
    .diff_o   (us_diff),
    .sub_o    (us_sub)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    x_d         = x_q;
    y_d         = y_q;
    diff_d      = diff_q;
    sub_d       = sub_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = unpack_op(A);
          b_d     = unpack_op({~B[31], B[30:0]});
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        x_d     = us_x;
        y_d     = us_y;
        diff_d  = us_diff;
        sub_d   = us_sub;
        state_d = (us_diff == '0) ? OP : ALIGN;
      end

      ALIGN: begin
        y_d    = shr_sticky(y_q);
        diff_d = diff_q - 8'd1;
        if (diff_q == 8'd1) state_d = OP;
      end

      OP: begin
        // X >= Y in magnitude, so the subtraction never borrows.
        x_d.mant = sub_q ? (x_q.mant - y_q) : (x_q.mant + y_q);
        state_d  = NORM;
      end

      NORM: begin
        if (x_q.mant == '0) begin
          x_d     = '0;
          state_d = DONE;
        end else if (x_q.mant[MANT_W-1]) begin
          if (x_q.exp == EXP_MAX - 8'd1) begin
            x_d.exp  = EXP_MAX;
            x_d.mant = '0;
            state_d  = DONE;
          end else begin
            x_d.mant = shr_sticky(x_q.mant);
            x_d.exp  = x_q.exp + 8'd1;
          end
        end else if (!x_q.mant[MANT_W-2]) begin
          // Another left shift would land on exp 0, which encodes zero.
          if (x_q.exp <= 8'd1) begin
            x_d.exp  = '0;
            x_d.mant = '0;
            state_d  = DONE;
          end else begin
            x_d.mant = x_q.mant << 1;
            x_d.exp  = x_q.exp - 8'd1;
          end
        end else begin
          state_d = DONE;
        end
      end

      DONE: begin
        out_d       = {x_q.sign, x_q.exp, x_q.mant[FRAC_W+2:3]};
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // The datapath registers are cleared too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      diff_q      <= '0;
      sub_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      x_q         <= x_d;
      y_q         <= y_d;
      diff_q      <= diff_d;
      sub_q       <= sub_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign Out       = out_q;

endmodule
